// File: rtl/div_share_ctrl.sv
// Shared radix-2 restoring divider with round-robin thread arbitration; DIV_ZERO_BYPASS_EN skips CALC for b==0.
// Latency: rsp_valid seen at acceptance edge +XLEN+2 (+2 for bypassed divide-by-zero); II = XLEN+3.
// Backpressure: result held in DONE until rsp_ready; no grants issued while busy.
module div_share_ctrl #(
    parameter int NUM_Threads = 4,
    parameter int XLEN        = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_Threads-1:0]          req_valid,
    input  logic [2*NUM_Threads-1:0]        req_op,
    input  logic [XLEN*NUM_Threads-1:0]     req_a,
    input  logic [XLEN*NUM_Threads-1:0]     req_b,
    output logic [NUM_Threads-1:0]          req_ready,
    output logic                            busy,
    output logic                            rsp_valid,
    output logic [$clog2(NUM_Threads)-1:0]  rsp_tid,
    output logic [XLEN-1:0]                 rsp_data,
    input  logic                            rsp_ready
);

    localparam int TW = $clog2(NUM_Threads);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t          state;
    logic [TW-1:0]   last_tid;
    logic [TW-1:0]   cur_tid;
    logic            op_rem;
    logic            q_neg;
    logic            r_neg;
    logic            b_zero;
    logic [XLEN-1:0] divisor;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [CW-1:0]   cnt;

    // Round-robin search starting just after the last accepted thread
    logic [TW-1:0] cand;
    logic [TW-1:0] grant_idx;
    logic          grant_any;

    always_comb begin
        cand      = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = 1; i <= NUM_Threads; i++) begin
            cand = last_tid + TW'(i);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Grant is suppressed while reset is held so nothing looks accepted during reset
    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_any && !rst)
            req_ready[grant_idx] = 1'b1;
    end

    assign busy = (state != IDLE);

    // Winner's request, converted to magnitudes for the unsigned core
    logic [1:0]      sel_op;
    logic [XLEN-1:0] sel_a;
    logic [XLEN-1:0] sel_b;
    logic            sel_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;

    always_comb begin
        sel_op     = req_op[grant_idx*2 +: 2];
        sel_a      = req_a[grant_idx*XLEN +: XLEN];
        sel_b      = req_b[grant_idx*XLEN +: XLEN];
        sel_signed = ~sel_op[0];
        a_neg      = sel_signed & sel_a[XLEN-1];
        b_neg      = sel_signed & sel_b[XLEN-1];
        a_mag      = a_neg ? -sel_a : sel_a;
        b_mag      = b_neg ? -sel_b : sel_b;
    end

    // One restoring step: the shifted partial remainder is XLEN+1 bits wide
    logic [XLEN:0] r_sh;
    logic [XLEN:0] r_sub;
    logic          geq;

    always_comb begin
        r_sh  = {rem, quo[XLEN-1]};
        r_sub = r_sh - {1'b0, divisor};
        geq   = ~r_sub[XLEN];
    end

    // Sign fix-up; divide-by-zero forces an all-ones quotient regardless of sign
    logic [XLEN-1:0] q_res;
    logic [XLEN-1:0] r_res;

    always_comb begin
        q_res = b_zero ? {XLEN{1'b1}} : (q_neg ? -quo : quo);
        r_res = r_neg ? -rem : rem;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_tid  <= TW'(NUM_Threads - 1);
            cur_tid   <= '0;
            op_rem    <= 1'b0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            b_zero    <= 1'b0;
            divisor   <= '0;
            quo       <= '0;
            rem       <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_tid   <= '0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        cur_tid  <= grant_idx;
                        last_tid <= grant_idx;
                        op_rem   <= sel_op[1];
                        q_neg    <= a_neg ^ b_neg;
                        r_neg    <= a_neg;
                        b_zero   <= (sel_b == '0);
                        divisor  <= b_mag;
                        quo      <= a_mag;
                        cnt      <= CW'(XLEN);
`ifdef DIV_ZERO_BYPASS_EN
                        // With b==0 the remainder is just |a|; go straight to sign fix-up
                        if (sel_b == '0) begin
                            rem   <= a_mag;
                            state <= FIXUP;
                        end else begin
                            rem   <= '0;
                            state <= CALC;
                        end
`else
                        rem      <= '0;
                        state    <= CALC;
`endif
                    end
                end
                CALC: begin
                    quo <= {quo[XLEN-2:0], geq};
                    rem <= geq ? r_sub[XLEN-1:0] : r_sh[XLEN-1:0];
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= FIXUP;
                end
                FIXUP: begin
                    rsp_data  <= op_rem ? r_res : q_res;
                    rsp_tid   <= cur_tid;
                    rsp_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl: arbitration order, arithmetic, latency, backpressure, reset.
module tb_div_share_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [7:0]   req_op;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_ready;
    logic         busy;
    logic         rsp_valid;
    logic [1:0]   rsp_tid;
    logic [31:0]  rsp_data;
    logic         rsp_ready;

    int total = 0;
    int bad   = 0;

`ifdef DIV_ZERO_BYPASS_EN
    localparam int ZLAT = 2;
`else
    localparam int ZLAT = 34;
`endif

    div_share_ctrl #(.NUM_Threads(4), .XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_tid   (rsp_tid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready)
    );

    always #5 clk = ~clk;

    task automatic set_req(input int t, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid[t]      = 1'b1;
        req_op[t*2 +: 2]  = op;
        req_a[t*32 +: 32] = a;
        req_b[t*32 +: 32] = b;
    endtask

    // Issue one request, return the grant seen, latency to rsp_valid, and the response; then handshake
    task automatic run_job(input int t, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [3:0] rdy, output int lat, output logic [31:0] data,
                           output logic [1:0] tid);
        set_req(t, op, a, b);
        #1;
        rdy = req_ready;
        @(posedge clk); #1;
        req_valid[t] = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        data = rsp_data;
        tid  = rsp_tid;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        total++; if (rsp_tid !== 2'd0) begin bad++; $display("FAIL reset_rsp_tid got %0d want 0", rsp_tid); end
        total++; if (rsp_data !== 32'd0) begin bad++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        req_valid = 4'hF;
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready_held got %b want 0000", req_ready); end
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_divu_basic();
        int lat;
        logic [31:0] data;
        logic [1:0]  tid;
        set_req(2, 2'b01, 32'd100, 32'd7);
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL basic_grant got %b want 0100", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got %b want 1", busy); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got %b want 0", rsp_valid); end
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        data = rsp_data;
        tid  = rsp_tid;
        total++; if (lat !== 34) begin bad++; $display("FAIL basic_latency got %0d want 34", lat); end
        total++; if (data !== 32'd14) begin bad++; $display("FAIL basic_data got %0d want 14", data); end
        total++; if (tid !== 2'd2) begin bad++; $display("FAIL basic_tid got %0d want 2", tid); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_release got %b want 0", busy); end
    endtask

    task automatic test_signed();
        logic [1:0]  ops [8] = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b11, 2'b01};
        logic [31:0] as  [8] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000, 32'h80000000,
                                 32'd7, 32'd7, 32'd100, 32'hFFFFFFFF};
        logic [31:0] bs  [8] = '{32'd2, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd7, 32'd1};
        logic [31:0] exp [8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'h00000000,
                                 32'hFFFFFFFD, 32'd1, 32'd2, 32'hFFFFFFFF};
        logic [3:0]  rdy;
        int          lat;
        logic [31:0] data;
        logic [1:0]  tid;
        for (int i = 0; i < 8; i++) begin
            run_job(i % 4, ops[i], as[i], bs[i], rdy, lat, data, tid);
            total++; if (data !== exp[i]) begin bad++; $display("FAIL signed_%0d data got %h want %h", i, data, exp[i]); end
            total++; if (tid !== 2'(i % 4)) begin bad++; $display("FAIL signed_%0d tid got %0d want %0d", i, tid, i % 4); end
            total++; if (lat !== 34) begin bad++; $display("FAIL signed_%0d latency got %0d want 34", i, lat); end
        end
    endtask

    task automatic test_div_zero();
        logic [1:0]  ops [4] = '{2'b01, 2'b11, 2'b00, 2'b10};
        logic [31:0] as  [4] = '{32'd5, 32'd5, 32'hFFFFFFFB, 32'hFFFFFFFB};
        logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFB};
        logic [3:0]  rdy;
        int          lat;
        logic [31:0] data;
        logic [1:0]  tid;
        for (int i = 0; i < 4; i++) begin
            run_job(3, ops[i], as[i], 32'd0, rdy, lat, data, tid);
            total++; if (data !== exp[i]) begin bad++; $display("FAIL divzero_%0d data got %h want %h", i, data, exp[i]); end
            total++; if (lat !== ZLAT) begin bad++; $display("FAIL divzero_%0d latency got %0d want %0d", i, lat, ZLAT); end
        end
    endtask

    task automatic test_backpressure();
        int n;
        set_req(1, 2'b01, 32'd1000, 32'd3);
        #1;
        @(posedge clk); #1;
        req_valid = '0;
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        set_req(0, 2'b01, 32'd9, 32'd3);
        set_req(3, 2'b01, 32'd8, 32'd2);
        for (int i = 0; i < 10; i++) begin
            #1;
            total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_%0d got %b want 1", i, rsp_valid); end
            total++; if (rsp_data !== 32'd333) begin bad++; $display("FAIL bp_data_%0d got %0d want 333", i, rsp_data); end
            total++; if (rsp_tid !== 2'd1) begin bad++; $display("FAIL bp_tid_%0d got %0d want 1", i, rsp_tid); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy_%0d got %b want 1", i, busy); end
            total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_grant_%0d got %b want 0000", i, req_ready); end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_release_busy got %b want 0", busy); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got %b want 0", rsp_valid); end
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL bp_next_grant got %b want 1000", req_ready); end
        req_valid = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_rem [4] = '{32'd2, 32'd1, 32'd0, 32'd9};
        logic [3:0]  exp_rdy;
        logic [31:0] d;
        logic [1:0]  tid;
        int          n;
        int          et;
        rst = 1'b1;
        for (int t = 0; t < 4; t++)
            set_req(t, 2'b10, 32'(100 + t * 13), 32'(7 + t));
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            et = j % 4;
            exp_rdy = 4'b0001 << et;
            #1;
            total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rr_grant_%0d got %b want %b", j, req_ready, exp_rdy); end
            @(posedge clk); #1;
            n = 0; d = '0; tid = '0;
            while (busy && n < 200) begin
                if (rsp_valid) begin
                    d   = rsp_data;
                    tid = rsp_tid;
                end
                @(posedge clk); #1;
                n++;
            end
            total++; if (n !== 34) begin bad++; $display("FAIL rr_busy_run_%0d got %0d want 34", j, n); end
            total++; if (tid !== 2'(et)) begin bad++; $display("FAIL rr_tid_%0d got %0d want %0d", j, tid, et); end
            total++; if (d !== exp_rem[et]) begin bad++; $display("FAIL rr_data_%0d got %0d want %0d", j, d, exp_rem[et]); end
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_calc();
        logic [3:0]  rdy;
        int          lat;
        logic [31:0] data;
        logic [1:0]  tid;
        set_req(0, 2'b01, 32'd50, 32'd5);
        #1;
        @(posedge clk); #1;
        req_valid = '0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got %b want 0", busy); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got %b want 0", rsp_valid); end
        set_req(1, 2'b01, 32'd90, 32'd9);
        set_req(3, 2'b11, 32'd90, 32'd7);
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL midrst_grant_in_reset got %b want 0000", req_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        run_job(1, 2'b01, 32'd90, 32'd9, rdy, lat, data, tid);
        total++; if (rdy !== 4'b0010) begin bad++; $display("FAIL midrst_first_grant got %b want 0010", rdy); end
        total++; if (tid !== 2'd1) begin bad++; $display("FAIL midrst_first_tid got %0d want 1", tid); end
        total++; if (data !== 32'd10) begin bad++; $display("FAIL midrst_first_data got %0d want 10", data); end
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL midrst_pending got %b want 1000", req_ready); end
        run_job(3, 2'b11, 32'd90, 32'd7, rdy, lat, data, tid);
        total++; if (tid !== 2'd3) begin bad++; $display("FAIL midrst_second_tid got %0d want 3", tid); end
        total++; if (data !== 32'd6) begin bad++; $display("FAIL midrst_second_data got %0d want 6", data); end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_div_zero();
        test_backpressure();
        test_round_robin();
        test_reset_mid_calc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
